// File: rtl/regfile_write_port_if.sv
// Write-back handshake bundle between the WB stage (master) and the register file write port (slave).
// A transfer happens on a rising edge where wb_valid && wb_ready; wb_ready depends on buffer state only,
// and a master that sees wb_ready low keeps wb_valid, wb_rd and wb_data stable until the transfer.
interface regfile_write_port_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (output wb_valid, output wb_rd, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_rd, input wb_data, output wb_ready);
endinterface

// File: rtl/regfile_write_port.sv
// Write side of the integer register file: a small in-order write buffer that commits one write per
// cycle into the register array, plus a per-register pending scoreboard for issue hazard checks.
module regfile_write_port #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 hold,
  regfile_write_port_if.slave  wb,
  output logic [NREG*XLEN-1:0] regs_flat,
  output logic [NREG-1:0]      pending,
  output logic [AW-1:0]        buf_count
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]   buf_rd   [DEPTH];
  logic [XLEN-1:0] buf_data [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] rf [1:NREG-1];
  logic [NREG-1:0] pend;

  logic            push;
  logic            pop;
  logic [AW-1:0]   head_rd;
  logic [XLEN-1:0] head_data;

  assign wb.wb_ready = (cnt != AW'(DEPTH));
  assign push        = wb.wb_valid && wb.wb_ready;
  // An entry pushed into an empty buffer is only visible to pop on the next edge: no wb->rf bypass.
  assign pop         = (cnt != '0) && !hold;
  assign head_rd     = buf_rd[head];
  assign head_data   = buf_data[head];

  // Buffer payload is not reset; the count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_rd[tail]   <= wb.wb_rd;
      buf_data[tail] <= wb.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + AW'(1);
        2'b01:   cnt <= cnt - AW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Register 0 has no storage; a drained x0 entry simply matches no row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) rf[i] <= '0;
    end else if (pop) begin
      for (int i = 1; i < NREG; i++) begin
        if (head_rd == AW'(i)) rf[i] <= head_data;
      end
    end
  end

  // Set takes priority over clear: a same-edge issue belongs to a newer instruction still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (iss_valid && iss_rd == AW'(i))   pend[i] <= 1'b1;
        else if (pop && head_rd == AW'(i))   pend[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 1; i < NREG; i++) regs_flat[XLEN*i +: XLEN] = rf[i];
  end

  assign pending   = pend;
  assign buf_count = cnt;

endmodule
